// File: rtl/ibex_cx_dispatch_pkg.sv
// rtl/ibex_cx_dispatch_pkg.sv - shared types and constants for the CX dispatcher
// Contents: cx_state_e FSM encoding, CX_FUNCT_W, CX_STAT_TIMEOUT_BIT,
//           cx_to_width() sizing helper for the timeout counter.
package ibex_cx_dispatch_pkg;

  localparam int CX_FUNCT_W          = 10;
  localparam int CX_STAT_TIMEOUT_BIT = 4;

  typedef enum logic [2:0] {
    CX_IDLE,
    CX_REQ,
    CX_RESP,
    CX_DONE,
    CX_ABORT
  } cx_state_e;

  // A disabled timeout (0) still needs a legal 1-bit counter.
  function automatic int cx_to_width(input int timeout_cyc);
    return (timeout_cyc <= 0) ? 1 : $clog2(timeout_cyc + 1);
  endfunction

endpackage

// File: rtl/ibex_cx_timeout_ctr.sv
// rtl/ibex_cx_timeout_ctr.sv - saturating wait counter for CX response timeout
// Ports: clk_i, rst_ni (sync, active low), clr_i (zero the count),
//        en_i (count this cycle), expired_o (count reached TIMEOUT_CYC-1 while enabled).
module ibex_cx_timeout_ctr
  import ibex_cx_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CX_TO_W = cx_to_width(TIMEOUT_CYC);
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

  logic [CX_TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT_CYC > 0) && en_i && (cnt_q == CX_TO_W'(TO_LAST));

endmodule

// File: rtl/ibex_cx_dispatch.sv
// rtl/ibex_cx_dispatch.sv - EX-stage dispatcher for composable-extension instructions
// Ports: ID side   cx_en_i, cx_funct_i, operand_a_i/b_i, kill_i, csr_cx_idx_i, csr_mcx_en_i
//        results   cx_ready_o, cx_result_o, cx_illegal_o, cx_stat_we_o, cx_stat_o
//        fabric    cx_req_{valid_o,ready_i,id_o,func_o,a_o,b_o},
//                  cx_resp_{valid_i,data_i,status_i,ready_o}
module ibex_cx_dispatch
  import ibex_cx_dispatch_pkg::*;
#(
  parameter int NUM_CX      = 4,
  parameter int CX_ID_W     = 8,
  parameter int STAT_W      = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cx_en_i,
  input  logic [CX_FUNCT_W-1:0] cx_funct_i,
  input  logic [31:0]           operand_a_i,
  input  logic [31:0]           operand_b_i,
  input  logic                  kill_i,
  input  logic [CX_ID_W-1:0]    csr_cx_idx_i,
  input  logic [NUM_CX-1:0]     csr_mcx_en_i,
  output logic                  cx_ready_o,
  output logic [31:0]           cx_result_o,
  output logic                  cx_illegal_o,
  output logic                  cx_stat_we_o,
  output logic [31:0]           cx_stat_o,
  output logic                  cx_req_valid_o,
  input  logic                  cx_req_ready_i,
  output logic [CX_ID_W-1:0]    cx_req_id_o,
  output logic [CX_FUNCT_W-1:0] cx_req_func_o,
  output logic [31:0]           cx_req_a_o,
  output logic [31:0]           cx_req_b_o,
  input  logic                  cx_resp_valid_i,
  input  logic [31:0]           cx_resp_data_i,
  input  logic [STAT_W-1:0]     cx_resp_status_i,
  output logic                  cx_resp_ready_o
);

  cx_state_e             state_q, state_d;
  logic                  kill_q, kill_d;
  logic [CX_ID_W-1:0]    req_id_q, req_id_d;
  logic [CX_FUNCT_W-1:0] req_func_q, req_func_d;
  logic [31:0]           req_a_q, req_a_d, req_b_q, req_b_d;
  logic [31:0]           result_q, result_d;
  logic [STAT_W-1:0]     status_q, status_d;
  logic                  to_q, to_d;
  logic                  legal, expired, to_en;

  // Matching against each unit index keeps out-of-range values illegal
  // without slicing the CSR index to a log2 width.
  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < NUM_CX; i++) begin
      if (csr_cx_idx_i == CX_ID_W'(i)) legal = csr_mcx_en_i[i];
    end
  end

  assign to_en = (state_q == CX_RESP) || (state_q == CX_ABORT);

  // Clearing on every state change covers both entry into RESP and into ABORT.
  ibex_cx_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (state_d != state_q),
    .en_i      (to_en),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= CX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CX_IDLE:  if (cx_en_i && legal && !kill_i) state_d = CX_REQ;
      CX_REQ:   if (cx_req_ready_i) state_d = (kill_q || kill_i) ? CX_ABORT : CX_RESP;
      CX_RESP: begin
        // Kill beats a same-cycle response; response beats timeout.
        if (kill_i)               state_d = CX_ABORT;
        else if (cx_resp_valid_i) state_d = CX_DONE;
        else if (expired)         state_d = CX_DONE;
      end
      CX_DONE:  state_d = CX_IDLE;
      CX_ABORT: if (cx_resp_valid_i || expired) state_d = CX_IDLE;
      default:  state_d = CX_IDLE;
    endcase
  end

  always_comb begin
    cx_req_valid_o  = (state_q == CX_REQ);
    cx_resp_ready_o = to_en;
    cx_ready_o      = (state_q == CX_DONE) && !kill_i;
    cx_stat_we_o    = (state_q == CX_DONE) && !kill_i;
    cx_illegal_o    = (state_q == CX_IDLE) && cx_en_i && !legal;
  end

  always_comb begin
    kill_d     = (state_q == CX_REQ) && (kill_q || kill_i);
    req_id_d   = req_id_q;
    req_func_d = req_func_q;
    req_a_d    = req_a_q;
    req_b_d    = req_b_q;
    result_d   = result_q;
    status_d   = status_q;
    to_d       = to_q;
    if ((state_q == CX_IDLE) && (state_d == CX_REQ)) begin
      req_id_d   = csr_cx_idx_i;
      req_func_d = cx_funct_i;
      req_a_d    = operand_a_i;
      req_b_d    = operand_b_i;
    end
    if ((state_q == CX_RESP) && !kill_i) begin
      if (cx_resp_valid_i) begin
        result_d = cx_resp_data_i;
        status_d = cx_resp_status_i;
        to_d     = 1'b0;
      end else if (expired) begin
        result_d = '0;
        status_d = '0;
        to_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      kill_q     <= 1'b0;
      req_id_q   <= '0;
      req_func_q <= '0;
      req_a_q    <= '0;
      req_b_q    <= '0;
      result_q   <= '0;
      status_q   <= '0;
      to_q       <= 1'b0;
    end else begin
      kill_q     <= kill_d;
      req_id_q   <= req_id_d;
      req_func_q <= req_func_d;
      req_a_q    <= req_a_d;
      req_b_q    <= req_b_d;
      result_q   <= result_d;
      status_q   <= status_d;
      to_q       <= to_d;
    end
  end

  assign cx_req_id_o   = req_id_q;
  assign cx_req_func_o = req_func_q;
  assign cx_req_a_o    = req_a_q;
  assign cx_req_b_o    = req_b_q;
  assign cx_result_o   = result_q;

  always_comb begin
    cx_stat_o                      = '0;
    cx_stat_o[STAT_W-1:0]          = status_q;
    cx_stat_o[CX_STAT_TIMEOUT_BIT] = to_q;
  end

endmodule

// File: tb/tb_ibex_cx_dispatch.sv
// tb/tb_ibex_cx_dispatch.sv - self-checking bench for ibex_cx_dispatch
module tb_ibex_cx_dispatch;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cx_en_i;
  logic [9:0]  cx_funct_i;
  logic [31:0] operand_a_i, operand_b_i;
  logic        kill_i;
  logic [7:0]  csr_cx_idx_i;
  logic [3:0]  csr_mcx_en_i;
  logic        cx_ready_o, cx_illegal_o, cx_stat_we_o;
  logic [31:0] cx_result_o, cx_stat_o;
  logic        cx_req_valid_o, cx_req_ready_i;
  logic [7:0]  cx_req_id_o;
  logic [9:0]  cx_req_func_o;
  logic [31:0] cx_req_a_o, cx_req_b_o;
  logic        cx_resp_valid_i;
  logic [31:0] cx_resp_data_i;
  logic [3:0]  cx_resp_status_i;
  logic        cx_resp_ready_o;

  int n_pass = 0;
  int n_chk  = 0;

  logic        o_ill, o_fok;
  int          o_nv, o_nr, o_nwe, o_rc, o_nresp;
  logic [31:0] o_res, o_stat;

  always #5 clk = ~clk;

  ibex_cx_dispatch #(
    .NUM_CX(4), .CX_ID_W(8), .STAT_W(4), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .cx_en_i(cx_en_i), .cx_funct_i(cx_funct_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .kill_i(kill_i),
    .csr_cx_idx_i(csr_cx_idx_i), .csr_mcx_en_i(csr_mcx_en_i),
    .cx_ready_o(cx_ready_o), .cx_result_o(cx_result_o), .cx_illegal_o(cx_illegal_o),
    .cx_stat_we_o(cx_stat_we_o), .cx_stat_o(cx_stat_o),
    .cx_req_valid_o(cx_req_valid_o), .cx_req_ready_i(cx_req_ready_i),
    .cx_req_id_o(cx_req_id_o), .cx_req_func_o(cx_req_func_o),
    .cx_req_a_o(cx_req_a_o), .cx_req_b_o(cx_req_b_o),
    .cx_resp_valid_i(cx_resp_valid_i), .cx_resp_data_i(cx_resp_data_i),
    .cx_resp_status_i(cx_resp_status_i), .cx_resp_ready_o(cx_resp_ready_o)
  );

  // Drives one instruction at c==0 and a reactive fabric, returning observations.
  task automatic run_op(input logic [7:0] idx, input logic [3:0] mask, input logic [9:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input int req_dly,
                        input int resp_dly, input logic [31:0] data, input logic [3:0] st,
                        input int kill_at, input int ncyc);
    int hs;
    hs = -1; o_ill = 1'b0; o_nv = 0; o_fok = 1'b1; o_nr = 0; o_nwe = 0; o_rc = -1;
    o_res = '0; o_stat = '0; o_nresp = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      cx_en_i          = (c == 0);
      csr_cx_idx_i     = (c == 0) ? idx  : 8'($urandom);
      csr_mcx_en_i     = (c == 0) ? mask : 4'($urandom);
      cx_funct_i       = (c == 0) ? fn   : 10'($urandom);
      operand_a_i      = (c == 0) ? a    : $urandom;
      operand_b_i      = (c == 0) ? b    : $urandom;
      kill_i           = (c == kill_at);
      cx_req_ready_i   = (hs < 0) && (c >= 1 + req_dly);
      cx_resp_valid_i  = (hs >= 0) && (o_nresp == 0) && (c >= hs + 1 + resp_dly);
      cx_resp_data_i   = cx_resp_valid_i ? data : $urandom;
      cx_resp_status_i = cx_resp_valid_i ? st : 4'($urandom);
      #1;
      if (c == 0) o_ill = cx_illegal_o;
      if (cx_req_valid_o) begin
        o_nv++;
        if ({cx_req_id_o, cx_req_func_o, cx_req_a_o, cx_req_b_o} !== {idx, fn, a, b}) o_fok = 1'b0;
        if (cx_req_ready_i) hs = c;
      end
      if (cx_resp_valid_i && cx_resp_ready_o) o_nresp++;
      if (cx_ready_o) begin
        o_nr++; o_rc = c; o_res = cx_result_o; o_stat = cx_stat_o;
      end
      if (cx_stat_we_o) o_nwe++;
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; cx_en_i = 0; cx_funct_i = 0; operand_a_i = 0; operand_b_i = 0; kill_i = 0;
    csr_cx_idx_i = 0; csr_mcx_en_i = 0; cx_req_ready_i = 0; cx_resp_valid_i = 0;
    cx_resp_data_i = 0; cx_resp_status_i = 0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({cx_ready_o, cx_illegal_o, cx_stat_we_o, cx_req_valid_o, cx_resp_ready_o} !== 5'b0)
      $display("FAIL reset_ctrl got %b exp 00000",
               {cx_ready_o, cx_illegal_o, cx_stat_we_o, cx_req_valid_o, cx_resp_ready_o});
    else n_pass++;
    n_chk++;
    if ({cx_req_id_o, cx_req_func_o, cx_req_a_o, cx_req_b_o} !== 82'b0)
      $display("FAIL reset_req got %h exp 0", {cx_req_id_o, cx_req_func_o, cx_req_a_o, cx_req_b_o});
    else n_pass++;
    n_chk++;
    if ({cx_result_o, cx_stat_o} !== 64'b0)
      $display("FAIL reset_res got %h exp 0", {cx_result_o, cx_stat_o});
    else n_pass++;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_basic;
    run_op(8'd1, 4'b0010, 10'h15, 32'd5, 32'd7, 0, 0, 32'd12, 4'd0, -1, 6);
    n_chk++; if (o_rc !== 3) $display("FAIL basic_latency got %0d exp 3", o_rc); else n_pass++;
    n_chk++; if (o_res !== 32'd12) $display("FAIL basic_result got %0d exp 12", o_res); else n_pass++;
    n_chk++; if (o_stat !== 32'd0) $display("FAIL basic_stat got %h exp 0", o_stat); else n_pass++;
    n_chk++; if (o_nwe !== 1) $display("FAIL basic_we got %0d exp 1", o_nwe); else n_pass++;
    n_chk++; if (o_fok !== 1'b1) $display("FAIL basic_fields got %b exp 1", o_fok); else n_pass++;
  endtask

  task automatic test_illegal;
    run_op(8'd2, 4'b0010, 10'h1, 32'd1, 32'd2, 0, 0, 32'd3, 4'd0, -1, 6);
    n_chk++; if (o_ill !== 1'b1) $display("FAIL ill_disabled got %b exp 1", o_ill); else n_pass++;
    n_chk++; if (o_nv !== 0) $display("FAIL ill_disabled_req got %0d exp 0", o_nv); else n_pass++;
    run_op(8'd5, 4'b1111, 10'h1, 32'd1, 32'd2, 0, 0, 32'd3, 4'd0, -1, 6);
    n_chk++; if (o_ill !== 1'b1) $display("FAIL ill_range got %b exp 1", o_ill); else n_pass++;
    n_chk++; if (o_nv + o_nr !== 0) $display("FAIL ill_range_req got %0d exp 0", o_nv + o_nr); else n_pass++;
  endtask

  task automatic test_backpressure;
    run_op(8'd3, 4'b1000, 10'h3ff, 32'hdead_beef, 32'h1234_5678, 4, 0, 32'h55, 4'd2, -1, 10);
    n_chk++; if (o_nv !== 5) $display("FAIL bp_valid_cycles got %0d exp 5", o_nv); else n_pass++;
    n_chk++; if (o_fok !== 1'b1) $display("FAIL bp_stable got %b exp 1", o_fok); else n_pass++;
    n_chk++; if (o_rc !== 7) $display("FAIL bp_latency got %0d exp 7", o_rc); else n_pass++;
    n_chk++; if (o_stat !== 32'd2) $display("FAIL bp_stat got %h exp 2", o_stat); else n_pass++;
  endtask

  task automatic test_timeout;
    run_op(8'd0, 4'b0001, 10'h7, 32'd9, 32'd9, 0, 100, 32'hffff, 4'd0, -1, 13);
    n_chk++; if (o_rc !== 10) $display("FAIL to_latency got %0d exp 10", o_rc); else n_pass++;
    n_chk++; if (o_res !== 32'd0) $display("FAIL to_result got %h exp 0", o_res); else n_pass++;
    n_chk++; if (o_stat !== 32'h10) $display("FAIL to_stat got %h exp 10", o_stat); else n_pass++;
    run_op(8'd0, 4'b0001, 10'h7, 32'd9, 32'd9, 0, 7, 32'habcd, 4'd1, -1, 13);
    n_chk++; if (o_rc !== 10) $display("FAIL to_edge_latency got %0d exp 10", o_rc); else n_pass++;
    n_chk++; if (o_stat !== 32'h1) $display("FAIL to_edge_stat got %h exp 1", o_stat); else n_pass++;
  endtask

  task automatic test_kill;
    run_op(8'd1, 4'b0010, 10'h2, 32'd1, 32'd1, 0, 3, 32'd77, 4'd0, 3, 7);
    n_chk++; if (o_nr + o_nwe !== 0) $display("FAIL kill_resp_strobes got %0d exp 0", o_nr + o_nwe); else n_pass++;
    n_chk++; if (o_nresp !== 1) $display("FAIL kill_resp_drain got %0d exp 1", o_nresp); else n_pass++;
    run_op(8'd1, 4'b0010, 10'h2, 32'd4, 32'd4, 0, 0, 32'd88, 4'd0, -1, 5);
    n_chk++; if (o_rc !== 3) $display("FAIL kill_then_op got %0d exp 3", o_rc); else n_pass++;
    run_op(8'd2, 4'b0100, 10'h2, 32'd1, 32'd1, 2, 1, 32'd66, 4'd0, 1, 7);
    n_chk++; if (o_nr !== 0 || o_nresp !== 1) $display("FAIL kill_req got %0d/%0d exp 0/1", o_nr, o_nresp); else n_pass++;
    run_op(8'd2, 4'b0100, 10'h2, 32'd1, 32'd1, 0, 0, 32'd66, 4'd0, 3, 4);
    n_chk++; if (o_nr + o_nwe !== 0) $display("FAIL kill_done got %0d exp 0", o_nr + o_nwe); else n_pass++;
  endtask

  task automatic test_back_to_back;
    run_op(8'd1, 4'b0011, 10'h11, 32'd1, 32'd2, 0, 0, 32'd100, 4'd3, -1, 4);
    n_chk++; if (o_res !== 32'd100 || o_rc !== 3) $display("FAIL b2b_first got %0d@%0d exp 100@3", o_res, o_rc); else n_pass++;
    run_op(8'd0, 4'b0011, 10'h22, 32'd3, 32'd4, 0, 0, 32'd200, 4'd0, -1, 4);
    n_chk++; if (o_res !== 32'd200 || o_rc !== 3) $display("FAIL b2b_second got %0d@%0d exp 200@3", o_res, o_rc); else n_pass++;
  endtask

  task automatic test_reset_mid;
    run_op(8'd1, 4'b0010, 10'h5, 32'd1, 32'd1, 6, 0, 32'd1, 4'd0, -1, 2);
    @(negedge clk);
    rst_ni = 1'b0; cx_req_ready_i = 1'b0; cx_en_i = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if ({cx_req_valid_o, cx_req_a_o} !== 33'b0) $display("FAIL reset_mid got %h exp 0", {cx_req_valid_o, cx_req_a_o});
    else n_pass++;
    rst_ni = 1'b1;
  endtask

  task automatic test_random;
    logic [7:0] idx; logic [3:0] mask, st; logic [9:0] fn; logic [31:0] a, b, data;
    int rq, rsp, r, e_rc; logic legal; logic [31:0] e_res, e_stat;
    for (int k = 0; k < 30; k++) begin
      idx = 8'($urandom_range(0, 6)); mask = 4'($urandom); fn = 10'($urandom);
      a = $urandom; b = $urandom; data = $urandom; st = 4'($urandom);
      rq = $urandom_range(0, 4); r = $urandom_range(0, 9); rsp = (r == 9) ? 100 : r;
      legal = (idx < 8'd4) && mask[idx[1:0]];
      if (rsp < 8) begin
        e_rc = 3 + rq + rsp; e_res = data; e_stat = {28'b0, st};
      end else begin
        e_rc = 10 + rq; e_res = 32'd0; e_stat = 32'h10;
      end
      run_op(idx, mask, fn, a, b, rq, rsp, data, st, -1, 14 + rq);
      n_chk++; if (o_ill !== !legal) $display("FAIL rnd%0d ill got %b exp %b", k, o_ill, !legal); else n_pass++;
      n_chk++; if (o_nr !== (legal ? 1 : 0)) $display("FAIL rnd%0d nready got %0d exp %0d", k, o_nr, legal ? 1 : 0); else n_pass++;
      n_chk++; if (o_nwe !== o_nr) $display("FAIL rnd%0d we got %0d exp %0d", k, o_nwe, o_nr); else n_pass++;
      if (legal) begin
        n_chk++; if (o_nv !== rq + 1) $display("FAIL rnd%0d nvalid got %0d exp %0d", k, o_nv, rq + 1); else n_pass++;
        n_chk++; if (o_fok !== 1'b1) $display("FAIL rnd%0d fields got %b exp 1", k, o_fok); else n_pass++;
        n_chk++; if (o_rc !== e_rc) $display("FAIL rnd%0d latency got %0d exp %0d", k, o_rc, e_rc); else n_pass++;
        n_chk++; if (o_res !== e_res) $display("FAIL rnd%0d result got %h exp %h", k, o_res, e_res); else n_pass++;
        n_chk++; if (o_stat !== e_stat) $display("FAIL rnd%0d stat got %h exp %h", k, o_stat, e_stat); else n_pass++;
      end else begin
        n_chk++; if (o_nv !== 0) $display("FAIL rnd%0d nvalid got %0d exp 0", k, o_nv); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_backpressure();
    test_timeout();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
